// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: MEM-stage to SRAM-like data bus bridge, one outstanding access,
// flushed transactions drained to completion without withdrawing the request.
module data_bus_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    input  logic        pipe_stall,
    output logic        stallreq,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;
    state_t state, state_nx;
    logic acc, acc_nx;
    logic issue, rd_done;
    assign issue    = state == IDLE && mem_en && !flush;
    assign rd_done  = !flush && bus_data_ok && !bus_wr &&
                      (state == DATA || (state == ADDR && bus_addr_ok));
    assign bus_req  = state == ADDR || (state == DRAIN && !acc);
    assign bus_wr   = |bus_wstrb;
    assign stallreq = issue || state == ADDR || state == DATA || state == DRAIN;
    // acc marks that a drained request already had its address accepted
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        case (state)
            IDLE: if (issue) begin
                state_nx = ADDR;
                acc_nx   = 1'b0;
            end
            ADDR: if (flush) begin
                state_nx = (bus_addr_ok && bus_data_ok) ? IDLE : DRAIN;
                acc_nx   = bus_addr_ok;
            end else if (bus_addr_ok) state_nx = bus_data_ok ? DONE : DATA;
            DATA: if (bus_data_ok) state_nx = flush ? IDLE : DONE;
            else if (flush) begin
                state_nx = DRAIN;
                acc_nx   = 1'b1;
            end
            DONE: if (flush || !pipe_stall) state_nx = IDLE;
            DRAIN: if (bus_data_ok && (acc || bus_addr_ok)) state_nx = IDLE;
            else if (bus_addr_ok) acc_nx = 1'b1;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 1'b0;
            bus_size  <= 2'd0;
            bus_wstrb <= 4'd0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            rdata     <= 32'd0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            if (issue) begin
                bus_size  <= mem_size;
                bus_wstrb <= mem_wen;
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
            end
            if (rd_done) rdata <= bus_rdata;
        end
    end
endmodule

// File: tb/tb_data_bus_ctrl.sv
// tb_data_bus_ctrl: directed scenarios plus randomized run against a transaction-level model.
module tb_data_bus_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic mem_en = 0, flush = 0, pipe_stall = 0, bus_addr_ok = 0, bus_data_ok = 0;
    logic [3:0] mem_wen = 0;
    logic [1:0] mem_size = 0;
    logic [31:0] mem_addr = 0, mem_wdata = 0, bus_rdata = 0;
    logic stallreq, bus_req, bus_wr;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [1:0] bus_size;
    logic [3:0] bus_wstrb;
    int checks = 0, errors = 0;

    data_bus_ctrl dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush), .pipe_stall(pipe_stall),
        .stallreq(stallreq), .rdata(rdata), .bus_req(bus_req), .bus_wr(bus_wr),
        .bus_size(bus_size), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata, rdata, stallreq} !== '0) begin errors++; $display("FAIL reset_outputs got req=%b wr=%b addr=%h rdata=%h stall=%b exp all 0", bus_req, bus_wr, bus_addr, rdata, stallreq); end
        step();
        rst = 0;
        step();
    endtask

    task automatic test_word_load();
        mem_en = 1; mem_wen = 0; mem_size = 2; mem_addr = 32'h8000_0010; #2;
        checks++; if ({bus_req, stallreq} !== 2'b01) begin errors++; $display("FAIL load_c0 got req/stall=%b%b exp 01", bus_req, stallreq); end
        step(); bus_addr_ok = 1; #2;
        checks++; if ({bus_req, stallreq, bus_wr} !== 3'b110) begin errors++; $display("FAIL load_c1 got req/stall/wr=%b%b%b exp 110", bus_req, stallreq, bus_wr); end
        checks++; if ({bus_addr, bus_size} !== {32'h8000_0010, 2'd2}) begin errors++; $display("FAIL load_c1_addr got %h/%0d exp 80000010/2", bus_addr, bus_size); end
        step(); bus_addr_ok = 0; #2;
        checks++; if ({bus_req, stallreq} !== 2'b01) begin errors++; $display("FAIL load_c2 got req/stall=%b%b exp 01", bus_req, stallreq); end
        step(); bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF; #2;
        checks++; if ({bus_req, stallreq} !== 2'b01) begin errors++; $display("FAIL load_c3 got req/stall=%b%b exp 01", bus_req, stallreq); end
        step(); bus_data_ok = 0; bus_rdata = 0; #2;
        checks++; if ({bus_req, stallreq, rdata} !== {2'b00, 32'hDEAD_BEEF}) begin errors++; $display("FAIL load_c4_done got req/stall=%b%b rdata=%h exp 00 deadbeef", bus_req, stallreq, rdata); end
        mem_en = 0; step();
    endtask

    task automatic test_byte_store();
        mem_en = 1; mem_wen = 4'b0100; mem_size = 0; mem_addr = 32'h0000_1002; mem_wdata = 32'h00AB_0000;
        step(); bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h5555_5555; #2;
        checks++; if ({bus_req, bus_wr, bus_wstrb, bus_size} !== {2'b11, 4'b0100, 2'd0}) begin errors++; $display("FAIL store_c1 got req=%b wr=%b wstrb=%b size=%0d exp 1 1 0100 0", bus_req, bus_wr, bus_wstrb, bus_size); end
        checks++; if (bus_wdata !== 32'h00AB_0000) begin errors++; $display("FAIL store_wdata got %h exp 00ab0000", bus_wdata); end
        step(); bus_addr_ok = 0; bus_data_ok = 0; #2;
        checks++; if ({stallreq, rdata} !== {1'b0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL store_c2_done got stall=%b rdata=%h exp 0 deadbeef", stallreq, rdata); end
        mem_en = 0; step();
    endtask

    task automatic test_flush_drain();
        mem_en = 1; mem_wen = 0; mem_size = 2; mem_addr = 32'h0000_0040;
        step(); bus_addr_ok = 1;
        step(); bus_addr_ok = 0; flush = 1; #2;
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL flush_c2_stall got %b exp 1", stallreq); end
        step(); flush = 0; mem_en = 0; #2;
        checks++; if ({bus_req, stallreq} !== 2'b01) begin errors++; $display("FAIL drain_c3 got req/stall=%b%b exp 01", bus_req, stallreq); end
        step(); bus_data_ok = 1; bus_rdata = 32'h1234_5678; #2;
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL drain_c4_stall got %b exp 1", stallreq); end
        step(); bus_data_ok = 0; bus_rdata = 0; mem_en = 1; mem_addr = 32'h0000_0080; #2;
        checks++; if ({bus_req, stallreq, rdata} !== {2'b01, 32'hDEAD_BEEF}) begin errors++; $display("FAIL drain_c5_idle got req/stall=%b%b rdata=%h exp 01 deadbeef", bus_req, stallreq, rdata); end
        step(); #2;
        checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h0000_0080}) begin errors++; $display("FAIL drain_next_req got req=%b addr=%h exp 1 00000080", bus_req, bus_addr); end
        bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hCAFE_0001;
        step(); bus_addr_ok = 0; bus_data_ok = 0; mem_en = 0;
        step();
    endtask

    task automatic test_stall_hold();
        mem_en = 1; mem_wen = 0; mem_size = 2; mem_addr = 32'h0000_0100;
        step(); bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h0BAD_F00D;
        step(); bus_addr_ok = 0; bus_data_ok = 0; pipe_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if ({bus_req, stallreq, rdata} !== {2'b00, 32'h0BAD_F00D}) begin errors++; $display("FAIL stall_hold_%0d got req/stall=%b%b rdata=%h exp 00 0badf00d", i, bus_req, stallreq, rdata); end
            step();
        end
        pipe_stall = 0; mem_addr = 32'h0000_0104; #2;
        checks++; if ({bus_req, stallreq} !== 2'b00) begin errors++; $display("FAIL stall_release got req/stall=%b%b exp 00", bus_req, stallreq); end
        step(); #2;
        checks++; if ({bus_req, stallreq} !== 2'b01) begin errors++; $display("FAIL stall_idle got req/stall=%b%b exp 01", bus_req, stallreq); end
        step(); #2;
        checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h0000_0104}) begin errors++; $display("FAIL stall_next_req got req=%b addr=%h exp 1 00000104", bus_req, bus_addr); end
        bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h7777_0000;
        step(); bus_addr_ok = 0; bus_data_ok = 0; mem_en = 0;
        step();
    endtask

    task automatic test_async_reset();
        mem_en = 1; mem_wen = 4'b1111; mem_size = 2; mem_addr = 32'h0000_0200; mem_wdata = 32'hA5A5_A5A5;
        step(); #2;
        checks++; if ({bus_req, bus_wr} !== 2'b11) begin errors++; $display("FAIL rst_pre got req/wr=%b%b exp 11", bus_req, bus_wr); end
        #1; rst = 1; mem_en = 0; #1;
        checks++; if ({bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata, rdata, stallreq} !== '0) begin errors++; $display("FAIL rst_async got req=%b wr=%b addr=%h wdata=%h rdata=%h exp all 0", bus_req, bus_wr, bus_addr, bus_wdata, rdata); end
        step(); rst = 0; mem_en = 1; mem_wen = 0; mem_addr = 32'h0000_0300; #2;
        checks++; if ({bus_req, stallreq} !== 2'b01) begin errors++; $display("FAIL rst_resample got req/stall=%b%b exp 01", bus_req, stallreq); end
        step(); #2;
        checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h0000_0300}) begin errors++; $display("FAIL rst_new_req got req=%b addr=%h exp 1 00000300", bus_req, bus_addr); end
        bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h0000_1111;
        step(); bus_addr_ok = 0; bus_data_ok = 0; mem_en = 0;
        step();
    endtask

    task automatic test_flush_idle();
        mem_en = 1; flush = 1; #2;
        checks++; if ({bus_req, stallreq} !== 2'b00) begin errors++; $display("FAIL flush_idle_c0 got req/stall=%b%b exp 00", bus_req, stallreq); end
        step(); #2;
        checks++; if ({bus_req, stallreq} !== 2'b00) begin errors++; $display("FAIL flush_idle_c1 got req/stall=%b%b exp 00", bus_req, stallreq); end
        flush = 0; mem_en = 0;
        step();
    endtask

    // Transaction-level model: one outstanding access, tracked by whether its
    // address was taken and whether its result has been cancelled by a flush.
    task automatic test_random();
        bit busy = 0, taken = 0, killed = 0, holding = 0, a;
        logic [3:0] w_q = 0; logic [1:0] s_q = 0; logic [31:0] a_q = 0, d_q = 0, r_q = 0;
        logic exp_req, exp_stall;
        rst = 1; step(); rst = 0;
        for (int n = 0; n < 3000; n++) begin
            mem_en = $urandom_range(3) != 0; mem_wen = ($urandom_range(1) != 0) ? 4'($urandom) : 4'd0;
            mem_size = 2'($urandom_range(2)); mem_addr = $urandom; mem_wdata = $urandom;
            flush = $urandom_range(9) == 0; pipe_stall = $urandom_range(1) != 0;
            bus_addr_ok = $urandom_range(1) != 0; bus_data_ok = $urandom_range(1) != 0; bus_rdata = $urandom;
            #2;
            exp_req = busy && !taken;
            exp_stall = busy || (!holding && mem_en && !flush);
            checks++;
            if ({bus_req, stallreq, bus_wr, bus_wstrb, bus_size, bus_addr, bus_wdata, rdata} !== {exp_req, exp_stall, |w_q, w_q, s_q, a_q, d_q, r_q}) begin
                errors++;
                $display("FAIL random_%0d got req=%b stall=%b wstrb=%b size=%0d addr=%h wdata=%h rdata=%h exp req=%b stall=%b wstrb=%b size=%0d addr=%h wdata=%h rdata=%h",
                         n, bus_req, stallreq, bus_wstrb, bus_size, bus_addr, bus_wdata, rdata, exp_req, exp_stall, w_q, s_q, a_q, d_q, r_q);
            end
            @(posedge clk);
            if (holding) begin
                if (flush || !pipe_stall) holding = 0;
            end else if (busy) begin
                a = taken || bus_addr_ok;
                if (a && bus_data_ok) begin
                    busy = 0;
                    if (!(killed || flush)) begin
                        holding = 1;
                        if (w_q == 0) r_q = bus_rdata;
                    end
                end else begin
                    taken = a; killed = killed || flush;
                end
            end else if (mem_en && !flush) begin
                busy = 1; taken = 0; killed = 0;
                w_q = mem_wen; s_q = mem_size; a_q = mem_addr; d_q = mem_wdata;
            end
            #1;
        end
        {mem_en, flush, pipe_stall, bus_addr_ok, bus_data_ok} = '0;
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_flush_drain();
        test_stall_hold();
        test_async_reset();
        test_flush_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
